// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared types for the instruction-fetch prefetch queue: PC and instruction
// words, and the queue entry that pairs a fetched word with its next-PC.
package fetch_prefetch_queue_pkg;

  localparam int PC_W     = 8;
  localparam int INSTR_W  = 32;
  localparam int PF_DEPTH = 4;

  typedef logic [PC_W-1:0]    ProgramCounter;
  typedef logic [INSTR_W-1:0] Instruction;

  typedef struct packed {
    ProgramCounter pc;     // fetch address + 1
    Instruction    instr;
  } PfEntry;

endpackage

// File: rtl/fetch_prefetch_queue_if.sv
// Handshake bundle between the fetch stage, the instruction ROM, the decode
// register and the memory-stage redirect source.
interface fetch_prefetch_queue_if
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = PF_DEPTH
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              stall;
  logic              redirect;
  ProgramCounter     redirect_pc;
  ProgramCounter     rom_addr;
  Instruction        rom_instr;
  logic              out_valid;
  ProgramCounter     out_pc;
  Instruction        out_instr;
  logic [CNT_W-1:0]  count;

  // Environment side: pipeline control, ROM data, and consumer of the head.
  modport master (
    output stall, redirect, redirect_pc, rom_instr,
    input  rom_addr, out_valid, out_pc, out_instr, count
  );

  // Fetch stage side.
  modport slave (
    input  stall, redirect, redirect_pc, rom_instr,
    output rom_addr, out_valid, out_pc, out_instr, count
  );

endinterface

// File: rtl/fetch_prefetch_queue_pf_fifo.sv
// Synchronous circular FIFO of PfEntry; flush empties it and beats push/pop.
module pf_fifo
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = PF_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  PfEntry           din,
  output PfEntry           dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  PfEntry           mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + PTR_W'(1);
      if (do_pop)  head <= head + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; pointers and count define which
  // entries are meaningful, and a reset-free array maps onto plain RAM/regs.
  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= din;
  end

  assign dout = empty ? '0 : mem[head];

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Fetch stage: owns fetch_pc, reads the ROM every cycle and buffers words in
// a prefetch queue so fetch runs ahead of a stalled decode.
module fetch_prefetch_queue
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = PF_DEPTH,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  fetch_prefetch_queue_if.slave  bus
);

  ProgramCounter    fetch_pc;
  ProgramCounter    next_pc;
  PfEntry           head_entry;
  PfEntry           push_entry;
  logic [CNT_W-1:0] fifo_count;
  logic             full;
  logic             empty;
  logic             deq;
  logic             enq;

  assign next_pc = fetch_pc + PC_W'(1);

  // Redirect kills both sides of the queue in the cycle it arrives.
  assign deq = ~empty & ~bus.stall & ~bus.redirect;
  assign enq = ~bus.redirect & (~full | deq);

  assign push_entry = '{pc: next_pc, instr: bus.rom_instr};

  pf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (bus.redirect),
    .push  (enq),
    .pop   (deq),
    .din   (push_entry),
    .dout  (head_entry),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst)               fetch_pc <= '0;
    else if (bus.redirect) fetch_pc <= bus.redirect_pc;
    else if (enq)          fetch_pc <= next_pc;
  end

  assign bus.rom_addr  = fetch_pc;
  assign bus.out_valid = ~empty;
  assign bus.out_pc    = head_entry.pc;
  assign bus.out_instr = head_entry.instr;
  assign bus.count     = fifo_count;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Self-checking bench: a scoreboard queue of expected head entries is pushed
// on predicted fetches and popped on predicted decode consumption.
module tb_fetch_prefetch_queue;
  import fetch_prefetch_queue_pkg::*;

  localparam int DEPTH = PF_DEPTH;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  fetch_prefetch_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_prefetch_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ROM image: word i holds i + 0x100.
  always_comb bus.rom_instr = 32'h100 + 32'(bus.rom_addr);

  PfEntry        sb[$];
  ProgramCounter m_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_state();
    PfEntry head;
    head = (sb.size() > 0) ? sb[0] : '0;
    check("count",     32'(bus.count),     32'(sb.size()));
    check("out_valid", 32'(bus.out_valid), 32'(sb.size() > 0));
    check("out_pc",    32'(bus.out_pc),    32'(head.pc));
    check("out_instr", bus.out_instr,      head.instr);
    check("rom_addr",  32'(bus.rom_addr),  32'(m_pc));
  endtask

  // Drive one cycle of inputs, predict the edge, then sample 1ns after it.
  task automatic cycle(input logic s, input logic r, input ProgramCounter rpc, input logic rs);
    logic deq;
    logic enq;
    rst             = rs;
    bus.stall       = s;
    bus.redirect    = r;
    bus.redirect_pc = rpc;
    if (rs) begin
      sb.delete();
      m_pc = '0;
    end else if (r) begin
      sb.delete();
      m_pc = rpc;
    end else begin
      deq = (sb.size() > 0) && !s;
      enq = (sb.size() < DEPTH) || deq;
      if (deq) void'(sb.pop_front());
      if (enq) begin
        sb.push_back('{pc: m_pc + 8'd1, instr: 32'h100 + 32'(m_pc)});
        m_pc = m_pc + 8'd1;
      end
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  initial begin
    rst             = 1'b1;
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    m_pc            = '0;
    @(posedge clk);
    #1;

    // 1: reset then free-run
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0);
    check("run_instr", bus.out_instr, 32'h105);
    check("run_pc",    32'(bus.out_pc), 32'h6);

    // 2: stall 6 cycles from reset, then release
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 8'h00, 1'b0);
    check("frozen_pc",  32'(bus.rom_addr), 32'h4);
    check("full_count", 32'(bus.count),    32'h4);
    // 3: full queue with stall released: enqueue and dequeue together
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0);

    // 4: redirect to 0x40 while stalled with three entries
    cycle(1'b0, 1'b1, 8'h10, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'h00, 1'b0);
    check("pre_redir_count", 32'(bus.count), 32'h3);
    cycle(1'b1, 1'b1, 8'h40, 1'b0);
    check("redir_addr", 32'(bus.rom_addr), 32'h40);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    check("redir_instr", bus.out_instr,     32'h140);
    check("redir_pc",    32'(bus.out_pc),   32'h41);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0);

    // 5: PC wrap from 0xFE
    cycle(1'b0, 1'b1, 8'hFE, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0);

    // 6: reset during a redirect with two entries queued
    cycle(1'b0, 1'b1, 8'h20, 1'b0);
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 8'h00, 1'b0);
    check("pre_rst_count", 32'(bus.count), 32'h2);
    cycle(1'b1, 1'b1, 8'h77, 1'b1);
    check("rst_addr", 32'(bus.rom_addr), 32'h0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0);

    // Random mix of stall and redirect against the scoreboard
    for (int i = 0; i < 200; i++)
      cycle(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 12) == 0),
            8'($urandom_range(0, 255)), 1'($urandom_range(0, 60) == 0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
